pe_rf_wb_arb: RTL and testbench
===============================

PE_RF_WB_ARB -- requirements
Module: pe_rf_wb_arb

Interface
REQ-001 The module SHALL have parameter NUM_SRC, default 3, the number of writeback sources.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 2, the entries per source queue (power of two, at least 2).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port wb_valid, input, 1 bit per source [NUM_SRC]: source s presents a write.
REQ-006 The module SHALL have port wb_ready, output, 1 bit per source [NUM_SRC]: source s queue can accept.
REQ-007 The module SHALL have port wb_rd, input, rf_reg (5 bits) per source: destination; [4:3] is the bank, [2:0] is the index.
REQ-008 The module SHALL have port wb_data, input, 32 bits per source: write value.
REQ-009 The module SHALL have port rf_we, output, 1 bit per bank [4]: write enable to register-file bank b.
REQ-010 The module SHALL have port rd, output, rf_reg per bank [4]: write address; bits [4:3] equal b whenever rf_we[b] is high.
REQ-011 The module SHALL have port rd_v, output, 32 bits per bank [4]: write data.
REQ-012 The module SHALL have port busy, output, 32 bits: bit r is high when any queued write targets register r.
REQ-013 The module SHALL have port idle, output, 1 bit: high when all source queues are empty.

Function
REQ-014 Each source SHALL own an in-order FIFO of FIFO_DEPTH entries, each holding {rd, data}.
REQ-015 wb_ready[s] SHALL equal "FIFO s not full", independent of same-cycle grants; there is no pass-through when full.
REQ-016 A push SHALL occur on a clock edge where wb_valid[s] and wb_ready[s] are both high; wb_valid while not ready SHALL be ignored with no state change.
REQ-017 Only the head entry of each non-empty FIFO SHALL be eligible; the head requests bank = head.rd[4:3].
REQ-018 Each bank SHALL have an independent round-robin arbiter over NUM_SRC sources with pointer ptr[b]; the search starts at source ptr[b] and proceeds upward, modulo NUM_SRC.
REQ-019 When bank b grants source g, rf_we[b], rd[b], and rd_v[b] SHALL be driven combinationally from FIFO g head in that cycle; the head SHALL pop at the next edge, and ptr[b] SHALL become (g+1) mod NUM_SRC.
REQ-020 When bank b has no request, ptr[b] SHALL hold, rf_we[b] SHALL be 0, and rd[b]/rd_v[b] SHALL be 0.
REQ-021 Up to four writes (one per bank) SHALL be issued per cycle; a source SHALL pop at most one entry per cycle.
REQ-022 Latency: an entry pushed at edge t into an empty FIFO with its bank uncontested SHALL appear on rf_we in the cycle after t, and the register file commits it at edge t+1.
REQ-023 A simultaneous push and pop on the same FIFO SHALL keep the count unchanged and preserve order; a push into a full FIFO cannot coincide with ready, so overflow is impossible.
REQ-024 The pointers and count SHALL wrap modulo FIFO_DEPTH with no lost or duplicated entries.
REQ-025 busy SHALL be a combinational OR over all valid entries of all FIFOs, including a head being written this cycle; the bit SHALL clear the cycle after the last matching entry pops.
REQ-026 Writes from different sources to the same register SHALL commit in grant order; same-source writes SHALL commit in push order.
REQ-027 idle SHALL be the AND of all FIFO-empty flags.

Reset
REQ-028 While rst is high, all FIFOs SHALL empty, ptr[b] SHALL be 0, rf_we SHALL be all 0, rd and rd_v SHALL be 0, busy SHALL be 0, idle SHALL be 1, and wb_ready SHALL be all 1.
REQ-029 An assertion of rst mid-operation SHALL discard queued writes immediately (asynchronously); no rf_we SHALL be issued for them afterward.

Verification
REQ-030 Single write: src0 pushes rd=5'b10_011, data=0xDEADBEEF -> next cycle rf_we[2]=1, rd[2]=5'b10_011, rd_v[2]=0xDEADBEEF; busy[19] high for exactly that cycle; then idle=1.
REQ-031 Bank conflict: src0, src1, src2 all push to bank 1 in one cycle -> grants src0, src1, src2 on consecutive cycles, ptr[1]=0 after the third; then the repeat stimulus yields src0 first again.
REQ-032 Parallel banks: src0->bank0, src1->bank3, src2->bank1 in the same cycle -> rf_we=4'b1011 in one cycle, with all data correct.
REQ-033 Backpressure: hold src0 bank-2 traffic while src1 wins bank 2 every other cycle -> wb_ready[0] drops after 2 queued entries, no entry lost, and order is preserved.
REQ-034 Reset mid-flight: 2 entries queued in src1, assert rst for one cycle -> busy=0, idle=1, and no rf_we pulse occurs afterward.
REQ-035 Random: 10k cycles of random valid/rd/data -> a scoreboard model matches the final register contents, and busy matches the model every cycle.

Source files
------------

// File: rtl/pe_rf_wb_arb.sv
// Register-file writeback arbiter: per-source in-order queues feeding four
// register banks, each with its own round-robin grant over the queue heads.
module pe_rf_wb_arb #(
    parameter int NUM_SRC    = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       wb_valid,
    output logic [NUM_SRC-1:0]       wb_ready,
    input  logic [NUM_SRC-1:0][4:0]  wb_rd,
    input  logic [NUM_SRC-1:0][31:0] wb_data,
    output logic [3:0]               rf_we,
    output logic [3:0][4:0]          rd,
    output logic [3:0][31:0]         rd_v,
    output logic [31:0]              busy,
    output logic                     idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    logic [4:0]   q_rd   [NUM_SRC][FIFO_DEPTH];
    logic [31:0]  q_data [NUM_SRC][FIFO_DEPTH];
    logic [AW-1:0] wp    [NUM_SRC];
    logic [AW-1:0] rp    [NUM_SRC];
    logic [AW:0]   cnt   [NUM_SRC];
    logic [SW-1:0] ptr   [4];
    logic [SW-1:0] gnt   [4];
    logic [3:0]    gnt_v;

    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] nonempty;

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            nonempty[s] = (cnt[s] != '0);
            wb_ready[s] = (cnt[s] != FULL);
            push[s]     = wb_valid[s] & wb_ready[s];
        end
        idle = ~|nonempty;
    end

    // Each head targets exactly one bank, so a source is popped at most once.
    always_comb begin
        gnt_v = '0;
        pop   = '0;
        rf_we = '0;
        rd    = '0;
        rd_v  = '0;
        for (int b = 0; b < 4; b++) begin
            gnt[b] = '0;
        end
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                int idx;
                idx = int'(ptr[b]) + i;
                if (idx >= NUM_SRC) begin
                    idx = idx - NUM_SRC;
                end
                if (!gnt_v[b] && nonempty[idx] &&
                    q_rd[idx][rp[idx]][4:3] == 2'(b)) begin
                    gnt_v[b]  = 1'b1;
                    gnt[b]    = SW'(idx);
                    pop[idx]  = 1'b1;
                    rf_we[b]  = 1'b1;
                    rd[b]     = q_rd[idx][rp[idx]];
                    rd_v[b]   = q_data[idx][rp[idx]];
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if ((AW+1)'(k) < cnt[s]) begin
                    busy[q_rd[s][rp[s] + AW'(k)]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                wp[s]  <= '0;
                rp[s]  <= '0;
                cnt[s] <= '0;
            end
            for (int b = 0; b < 4; b++) begin
                ptr[b] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (push[s]) begin
                    wp[s] <= wp[s] + 1'b1;
                end
                if (pop[s]) begin
                    rp[s] <= rp[s] + 1'b1;
                end
                if (push[s] && !pop[s]) begin
                    cnt[s] <= cnt[s] + 1'b1;
                end else if (!push[s] && pop[s]) begin
                    cnt[s] <= cnt[s] - 1'b1;
                end
            end
            for (int b = 0; b < 4; b++) begin
                if (gnt_v[b]) begin
                    if (int'(gnt[b]) == NUM_SRC - 1) begin
                        ptr[b] <= '0;
                    end else begin
                        ptr[b] <= gnt[b] + 1'b1;
                    end
                end
            end
        end
    end

    // Queue storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (push[s]) begin
                q_rd[s][wp[s]]   <= wb_rd[s];
                q_data[s][wp[s]] <= wb_data[s];
            end
        end
    end

endmodule

// File: tb/tb_pe_rf_wb_arb.sv
// Scoreboard bench for pe_rf_wb_arb: a queue-level model predicts grants,
// busy, idle and ready each cycle; a negedge monitor compares.
module tb_pe_rf_wb_arb;

    localparam int NS    = 3;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    typedef struct packed {
        logic [31:0]   busy;
        logic          idle;
        logic [NS-1:0] ready;
    } exp_c_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NS-1:0]       wb_valid;
    logic [NS-1:0]       wb_ready;
    logic [NS-1:0][4:0]  wb_rd;
    logic [NS-1:0][31:0] wb_data;
    logic [3:0]          rf_we;
    logic [3:0][4:0]     rd;
    logic [3:0][31:0]    rd_v;
    logic [31:0]         busy;
    logic                idle;

    pe_rf_wb_arb #(.NUM_SRC(NS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_we(rf_we), .rd(rd), .rd_v(rd_v),
        .busy(busy), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    ent_t   mq [NS][$];
    int     mptr [4];
    int     mgnt [4];
    logic [NS-1:0] mpush;
    logic [31:0] rf_model [32];
    logic [31:0] dut_rf [32];

    ent_t   exp_q [4][$];
    exp_c_t exp_c [$];

    logic [NS-1:0]       sv;
    logic [NS-1:0][4:0]  sr;
    logic [NS-1:0][31:0] sd;

    logic running = 1'b1;
    int   seen_1011 = 0;
    int   seen_nr0 = 0;
    int   we_after_rst = 0;
    int   watch_we = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++) mq[s].delete();
        for (int b = 0; b < 4; b++) begin
            mptr[b] = 0;
            mgnt[b] = -1;
            exp_q[b].delete();
        end
        exp_c.delete();
    endtask

    // Predict this cycle's grants and status from the queue contents.
    task automatic model_grant();
        exp_c_t e;
        e.busy = '0;
        for (int s = 0; s < NS; s++) begin
            foreach (mq[s][k]) e.busy[mq[s][k].r] = 1'b1;
            e.ready[s] = (mq[s].size() < DEPTH);
        end
        e.idle = 1'b1;
        for (int s = 0; s < NS; s++)
            if (mq[s].size() != 0) e.idle = 1'b0;
        exp_c.push_back(e);
        for (int b = 0; b < 4; b++) begin
            mgnt[b] = -1;
            for (int i = 0; i < NS; i++) begin
                int s;
                s = (mptr[b] + i) % NS;
                if (mgnt[b] < 0 && mq[s].size() != 0 &&
                    int'(mq[s][0].r[4:3]) == b) begin
                    mgnt[b] = s;
                    exp_q[b].push_back(mq[s][0]);
                    rf_model[mq[s][0].r] = mq[s][0].d;
                end
            end
        end
    endtask

    task automatic model_commit();
        for (int b = 0; b < 4; b++) begin
            if (mgnt[b] >= 0) begin
                void'(mq[mgnt[b]].pop_front());
                mptr[b] = (mgnt[b] + 1) % NS;
            end
        end
        for (int s = 0; s < NS; s++) begin
            if (mpush[s]) mq[s].push_back('{r: sr[s], d: sd[s]});
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle();
        model_grant();
        wb_valid = sv;
        wb_rd    = sr;
        wb_data  = sd;
        for (int s = 0; s < NS; s++)
            mpush[s] = sv[s] && (mq[s].size() < DEPTH);
        @(posedge clk);
        #1;
        model_commit();
        sv = '0;
        wb_valid = '0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        sv = '0;
        wb_valid = '0;
        model_clear();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (running) begin
            if (rst) begin
                chk("rst_we", 32'(rf_we), 32'h0);
                chk("rst_busy", busy, 32'h0);
                chk("rst_idle", 32'(idle), 32'h1);
                chk("rst_ready", 32'(wb_ready), 32'((1 << NS) - 1));
            end else begin
                exp_c_t e;
                if (exp_c.size() == 0) begin
                    chk("have_expect", 32'h0, 32'h1);
                end else begin
                    e = exp_c.pop_front();
                    chk("busy", busy, e.busy);
                    chk("idle", 32'(idle), 32'(e.idle));
                    chk("ready", 32'(wb_ready), 32'(e.ready));
                end
                if (rf_we == 4'b1011) seen_1011++;
                if (!wb_ready[0]) seen_nr0++;
                if (watch_we != 0 && rf_we != 4'b0) we_after_rst++;
                for (int b = 0; b < 4; b++) begin
                    ent_t x;
                    if (rf_we[b]) begin
                        dut_rf[rd[b]] = rd_v[b];
                        if (exp_q[b].size() == 0) begin
                            chk($sformatf("unexp_we%0d", b), 32'h1, 32'h0);
                        end else begin
                            x = exp_q[b].pop_front();
                            chk($sformatf("rd%0d", b), 32'(rd[b]), 32'(x.r));
                            chk($sformatf("rd_v%0d", b), rd_v[b], x.d);
                        end
                    end else if (exp_q[b].size() != 0) begin
                        x = exp_q[b].pop_front();
                        chk($sformatf("miss_we%0d", b), 32'h0, 32'h1);
                        chk($sformatf("idle_rd%0d", b), 32'(rd[b]), 32'h0);
                    end else begin
                        chk($sformatf("idle_rd%0d", b),
                            32'(rd[b]) | rd_v[b], 32'h0);
                    end
                end
            end
        end
    end

    initial begin
        int k0;
        int k1;
        rst = 1'b1;
        sv = '0;
        sr = '0;
        sd = '0;
        wb_valid = '0;
        wb_rd = '0;
        wb_data = '0;
        mpush = '0;
        for (int i = 0; i < 32; i++) begin
            rf_model[i] = 32'h0;
            dut_rf[i] = 32'h0;
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // single write
        sv = 3'b001;
        sr[0] = 5'b10_011;
        sd[0] = 32'hDEAD_BEEF;
        cycle();
        repeat (3) cycle();

        // three sources contend for bank 1, twice
        for (int rep = 0; rep < 2; rep++) begin
            sv = 3'b111;
            for (int s = 0; s < NS; s++) begin
                sr[s] = {2'b01, 3'(s + 4 * rep)};
                sd[s] = 32'h1100_0000 + 32'(16 * rep + s);
            end
            cycle();
            repeat (4) cycle();
        end

        // parallel banks
        sv = 3'b111;
        sr[0] = 5'b00_101;
        sr[1] = 5'b11_010;
        sr[2] = 5'b01_110;
        sd[0] = 32'hA0A0_0001;
        sd[1] = 32'hB0B0_0002;
        sd[2] = 32'hC0C0_0003;
        cycle();
        repeat (2) cycle();
        chk("par_1011", 32'(seen_1011 > 0), 32'h1);

        // backpressure on bank 2
        k0 = 0;
        k1 = 0;
        for (int c = 0; c < 16; c++) begin
            sv = 3'b011;
            sr[0] = {2'b10, 3'(k0)};
            sd[0] = 32'hA000_0000 + 32'(k0);
            sr[1] = 5'b10_111;
            sd[1] = 32'hB000_0000 + 32'(k1);
            cycle();
            if (mpush[0]) k0++;
            if (mpush[1]) k1++;
        end
        repeat (8) cycle();
        chk("bp_ready_low", 32'(seen_nr0 > 0), 32'h1);

        // reset with src1 backed up behind bank-0 contention
        for (int c = 0; c < 3; c++) begin
            sv = 3'b111;
            for (int s = 0; s < NS; s++) begin
                sr[s] = {2'b00, 3'(s + c)};
                sd[s] = 32'hD000_0000 + 32'(c * 4 + s);
            end
            cycle();
        end
        do_reset(1);
        watch_we = 1;
        repeat (4) cycle();
        watch_we = 0;
        chk("no_we_after_rst", 32'(we_after_rst), 32'h0);

        // random traffic
        for (int c = 0; c < 10000; c++) begin
            sv = NS'($urandom);
            for (int s = 0; s < NS; s++) begin
                sr[s] = 5'($urandom);
                sd[s] = $urandom;
            end
            cycle();
        end
        repeat (8) cycle();
        running = 1'b0;

        for (int i = 0; i < 32; i++)
            chk($sformatf("rf[%0d]", i), dut_rf[i], rf_model[i]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
